// File: rtl/clause_reduce_scheduler.sv
// Sequences one bound-computation pass over N clauses: issues one clause per cycle to the reducer,
// folds each reducer result (valid one cycle after issue) into running upper/lower bounds.
module clause_reduce_scheduler #(
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_COEFFICIENT    = 8,
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX = 1,
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_CLAUSE_INDEX   = 2
) (
  input  logic                                           in_clk,
  input  logic                                           in_reset,
  input  logic                                           in_start,
  input  logic [MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX-1:0] in_variable_index,
  input  logic [MAXIMUM_BIT_WIDTH_OF_CLAUSE_INDEX:0]     in_number_of_clauses,
  output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSE_INDEX-1:0]   out_clause_index,
  output logic [MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX-1:0] out_variable_index,
  output logic                                           out_reduce_enable,
  input  logic signed [MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0] in_bias,
  input  logic                                           in_sign,
  input  logic                                           in_active,
  output logic signed [MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0] out_upper_bound,
  output logic signed [MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0] out_lower_bound,
  output logic                                           out_upper_valid,
  output logic                                           out_lower_valid,
  output logic                                           out_infeasible,
  output logic                                           out_busy,
  output logic                                           out_done
);

  localparam int unsigned W  = MAXIMUM_BIT_WIDTH_OF_COEFFICIENT;
  localparam int unsigned VW = MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX;
  localparam int unsigned CW = MAXIMUM_BIT_WIDTH_OF_CLAUSE_INDEX;

  localparam logic signed [W-1:0] BOUND_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] BOUND_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_accept;
  logic                  w_last;
  logic [CW-1:0]         r_k;
  logic [CW:0]           r_count;
  logic                  r_pending;
  logic                  r_enable;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_infeasible;
  logic [VW-1:0]         r_variable_index;
  logic signed [W-1:0]   r_upper;
  logic signed [W-1:0]   r_lower;
  logic                  r_upper_valid;
  logic                  r_lower_valid;
  logic signed [W-1:0]   w_upper_nxt;
  logic signed [W-1:0]   w_lower_nxt;
  logic                  w_upper_valid_nxt;
  logic                  w_lower_valid_nxt;
  logic signed [W-1:0]   w_candidate;

  always_ff @(posedge in_clk) begin
    if (in_reset) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_last       = ((CW+1)'(r_k) + (CW+1)'(1)) == r_count;
    case (r_state)
      S_IDLE: begin
        if (in_start) begin
          w_accept     = 1'b1;
          w_next_state = (in_number_of_clauses == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: if (w_last) w_next_state = S_DRAIN;
      S_DRAIN: w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Bound folding; negating the most negative bias would wrap, so it saturates instead.
  always_comb begin
    w_upper_nxt       = r_upper;
    w_lower_nxt       = r_lower;
    w_upper_valid_nxt = r_upper_valid;
    w_lower_valid_nxt = r_lower_valid;
    w_candidate       = (in_bias == BOUND_MIN) ? BOUND_MAX : -in_bias;
    if (w_accept) begin
      w_upper_nxt       = BOUND_MAX;
      w_lower_nxt       = BOUND_MIN;
      w_upper_valid_nxt = 1'b0;
      w_lower_valid_nxt = 1'b0;
    end else if (r_pending && in_active) begin
      if (in_sign) begin
        if (in_bias < r_upper) w_upper_nxt = in_bias;
        w_upper_valid_nxt = 1'b1;
      end else begin
        if (w_candidate > r_lower) w_lower_nxt = w_candidate;
        w_lower_valid_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      r_k              <= '0;
      r_count          <= '0;
      r_pending        <= 1'b0;
      r_enable         <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_infeasible     <= 1'b0;
      r_variable_index <= '0;
      r_upper          <= BOUND_MAX;
      r_lower          <= BOUND_MIN;
      r_upper_valid    <= 1'b0;
      r_lower_valid    <= 1'b0;
    end else begin
      r_enable      <= (w_next_state == S_ISSUE);
      r_busy        <= (w_next_state == S_ISSUE) || (w_next_state == S_DRAIN);
      r_done        <= (w_next_state == S_DONE);
      r_pending     <= (r_state == S_ISSUE);
      r_upper       <= w_upper_nxt;
      r_lower       <= w_lower_nxt;
      r_upper_valid <= w_upper_valid_nxt;
      r_lower_valid <= w_lower_valid_nxt;
      if (w_accept) begin
        r_k              <= '0;
        r_count          <= in_number_of_clauses;
        r_variable_index <= in_variable_index;
      end else if (r_state == S_ISSUE && !w_last) begin
        r_k <= r_k + CW'(1);
      end
      if (w_next_state == S_DONE && r_state != S_DONE)
        r_infeasible <= w_upper_valid_nxt && w_lower_valid_nxt && (w_lower_nxt > w_upper_nxt);
      else if (w_accept)
        r_infeasible <= 1'b0;
    end
  end

  assign out_clause_index   = r_k;
  assign out_variable_index = r_variable_index;
  assign out_reduce_enable  = r_enable;
  assign out_upper_bound    = r_upper;
  assign out_lower_bound    = r_lower;
  assign out_upper_valid    = r_upper_valid;
  assign out_lower_valid    = r_lower_valid;
  assign out_infeasible     = r_infeasible;
  assign out_busy           = r_busy;
  assign out_done           = r_done;

endmodule
